vout_7seg_pager: RTL and testbench
==================================

# vout_7seg_pager

Scan and page controller for a 4-digit multiplexed 7-segment display. Up to four requesters (pages) each present a 16-bit unsigned value. The block chooses the page to show round-robin with a programmable dwell, converts the value to BCD sequentially, and drives the digit enables and segments with an anti-ghosting blank window in each slot. It sits between the vout value registers and the display pins, and it sequences and shares the display resource.

## Interface
- SCAN_DIV, 256: clock cycles per digit slot (≥ 8); one frame is 4 slots.
- BLANK_CYCLES, 16: cycles at the start of each slot with every digit off (< SCAN_DIV).
- DWELL_FRAMES, 1024: frames a page is shown before the arbiter rotates (≥ 1).
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- value0..value3  in  16 each  unsigned page values.
- valid  in  4  page i is eligible for display.
- hold  in  1  freeze page rotation.
- en  out  4  digit enables, active-low; en[0] is the ones digit.
- seg  out  7  segments, active-high; bit0=A … bit6=G.
- dp  out  1  decimal point, active-high.
- page  out  2  index of the current page.

## Operation
- Scan counters: slot_cnt runs 0..SCAN_DIV-1. digit_idx runs 0..3 and increments when slot_cnt wraps. A frame boundary is the wrap of slot_cnt with digit_idx=3.
- Blank window: while slot_cnt < BLANK_CYCLES, en=1111 and seg=0. Otherwise en[digit_idx]=0, the other enables are 1, and seg shows the digit glyph.
- Glyphs: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Blank is 0000000. Dash is 1000000.
- Leading-zero suppression: digits above the most significant nonzero digit show blank. Value 0 shows "0" on digit 0 only.
- Overflow: a value > 9999 shows dash on all four digits.
- dp=1 only in the non-blank part of slot digit_idx==page. No page is marked when nothing is displayed.
- Arbiter, evaluated only at frame boundaries:
  - The dwell counter counts frames.
  - Rotate when the dwell counter reaches DWELL_FRAMES-1 and hold=0, or when valid[page]=0.
  - Next page is the first valid index after the current one, ascending with wrap 3→0.
  - If the current page is the only valid one, page stays put.
  - The dwell counter clears on every page change.
  - hold=1 blocks dwell rotation only. Loss of valid still forces a change.
  - valid=0000: page holds, dwell clears, and the display is blank from the next commit.
- Converter FSM, states IDLE → LOAD → SHIFT(16 iterations) → DONE:
  - At a frame boundary, two things happen in the same cycle: the pending BCD result is committed to the display register, and the value of the page selected for the new frame is snapshotted into LOAD.
  - SHIFT is double-dabble: add 3 to any nibble ≥ 5 across 5 nibbles, then shift in the next MSB. 20-bit result.
  - DONE writes the pending register, then the FSM returns to IDLE.
  - Total is 18 cycles, always complete before the next boundary (4·SCAN_DIV ≥ 32).
- Value changes between boundaries are ignored until the next snapshot.

## Timing
- Reset values: en=1111, seg=0000000, dp=0, page=0. All counters are 0, the converter is IDLE, and the pending and display registers hold blank.
- The first cycle after rst_n rises is frame boundary 0, which takes a snapshot.
- en, seg and dp are registered, so they change one cycle after the counter state that selects them.
- Latency: a value snapshotted at boundary k is displayed from boundary k+1 (4·SCAN_DIV cycles).
- A page change at boundary k snapshots the new page's value in that same cycle. It is displayed from k+1; during frame k the previous page's digits remain, with dp tracking the new page.
- Reset asserted mid-conversion or mid-slot returns every output to its reset value on the next clock edge. The pending result is discarded.

## Test plan
Use SCAN_DIV=32, BLANK_CYCLES=4, DWELL_FRAMES=2.
- **Reset:** hold rst_n=0 for 5 cycles, then release with valid=0001 and value0=1234 → en=1111, seg=0 and dp=0 during reset; frame 0 shows blank on every digit.
- **Value display:** valid=0001, value0=1234, from frame 1 onward → digit0 slot shows seg=1100110 ("4"), digit3 shows 0000110 ("1"); each slot's first 4 cycles have en=1111; dp is 1 only in the digit0 slot.
- **Leading zeros:** value0=7 → digit0 shows 0000111 and digits 1–3 show 0000000. value0=0 → digit0 shows 0111111. value0=12345 → all digits show 1000000.
- **Rotation:** valid=1011, hold=0 → page sequence 0,0,1,1,3,3,0 per frame; each page's value appears one frame after page changes.
- **Valid drop:** drop valid[1] during page 1 → page moves to 3 at the next boundary. With hold=1, page stays while valid; hold=1 with valid[page] dropped still rotates. valid=0000 → blank display after one frame, page unchanged.
- **Reset mid-conversion:** assert rst_n=0 for 1 cycle at cycle 5 of a conversion → outputs return to reset values; the next display comes only from a fresh snapshot.

Source files
------------

// File: rtl/vout_7seg_pager.sv
// Round-robin page selector and multiplexed 4-digit 7-segment driver.
// Each frame commits the previous frame's BCD result and converts the next page's value.
module vout_7seg_pager #(
    parameter int SCAN_DIV     = 256,
    parameter int BLANK_CYCLES = 16,
    parameter int DWELL_FRAMES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    input  logic [15:0] value2,
    input  logic [15:0] value3,
    input  logic [3:0]  valid,
    input  logic        hold,
    output logic [3:0]  en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  page
);

    localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_VIS  = SLOT_W'(BLANK_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_FRAMES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [6:0] GLYPH_DASH = 7'b1000000;

    logic [SLOT_W-1:0]  r_slot;
    logic [1:0]         r_digit;
    logic               r_first;
    logic [1:0]         r_page;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_state;
    logic [3:0]         r_iter;
    logic               r_snap_on;
    logic               r_pend_on;
    logic               r_disp_on;
    logic [15:0]        r_snap_val;
    logic [35:0]        r_dd;
    logic [19:0]        r_pend_bcd;
    logic [19:0]        r_disp_bcd;

    logic               w_slot_wrap;
    logic               w_boundary;
    logic               w_rotate;
    logic [1:0]         w_next_page;
    logic [DWELL_W-1:0] w_next_dwell;
    logic [15:0]        w_sel_val;
    logic [3:0]         w_nib;
    logic               w_show;
    logic [6:0]         w_glyph;

    function automatic logic [1:0] f_next_valid(input logic [3:0] v, input logic [1:0] p);
        logic [1:0] n;
        logic [1:0] idx;
        n = p;
        // Descending scan so the nearest valid index after p wins.
        for (int k = 3; k >= 1; k--) begin
            idx = p + 2'(k);
            if (v[idx]) n = idx;
        end
        return n;
    endfunction

    function automatic logic [35:0] f_dd_step(input logic [35:0] x);
        logic [35:0] a;
        a = x;
        for (int n = 0; n < 5; n++) begin
            if (a[16+4*n +: 4] >= 4'd5) a[16+4*n +: 4] = a[16+4*n +: 4] + 4'd3;
        end
        return {a[34:0], 1'b0};
    endfunction

    function automatic logic [6:0] f_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign w_slot_wrap = (r_slot == SLOT_LAST);
    // The first cycle out of reset acts as a boundary so a snapshot is taken immediately.
    assign w_boundary  = r_first || (w_slot_wrap && (r_digit == 2'd3));
    assign page        = r_page;

    always_comb begin
        w_next_page  = r_page;
        w_next_dwell = r_dwell;
        w_rotate     = (valid != 4'b0000) &&
                       (!valid[r_page] || (!r_first && !hold && (r_dwell == DWELL_MAX)));
        if (valid == 4'b0000) begin
            w_next_dwell = '0;
        end else if (w_rotate) begin
            w_next_dwell = '0;
            w_next_page  = f_next_valid(valid, r_page);
        end else if (!r_first && (r_dwell < DWELL_MAX)) begin
            w_next_dwell = r_dwell + 1'b1;
        end
    end

    always_comb begin
        case (w_next_page)
            2'd0:    w_sel_val = value0;
            2'd1:    w_sel_val = value1;
            2'd2:    w_sel_val = value2;
            default: w_sel_val = value3;
        endcase
    end

    always_comb begin
        w_nib = r_disp_bcd[{r_digit, 2'b00} +: 4];
        case (r_digit)
            2'd0:    w_show = 1'b1;
            2'd1:    w_show = |r_disp_bcd[15:4];
            2'd2:    w_show = |r_disp_bcd[15:8];
            default: w_show = |r_disp_bcd[15:12];
        endcase
        if (!r_disp_on)               w_glyph = 7'b0000000;
        else if (|r_disp_bcd[19:16])  w_glyph = GLYPH_DASH;
        else if (w_show)              w_glyph = f_glyph(w_nib);
        else                          w_glyph = 7'b0000000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_digit <= 2'd0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            r_slot  <= w_slot_wrap ? '0 : r_slot + 1'b1;
            if (w_slot_wrap) r_digit <= r_digit + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_page    <= 2'd0;
            r_dwell   <= '0;
            r_state   <= S_IDLE;
            r_iter    <= 4'd0;
            r_snap_on <= 1'b0;
            r_pend_on <= 1'b0;
            r_disp_on <= 1'b0;
        end else if (w_boundary) begin
            r_page    <= w_next_page;
            r_dwell   <= w_next_dwell;
            r_disp_on <= r_pend_on;
            r_snap_on <= (valid != 4'b0000);
            r_state   <= S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_iter  <= 4'd0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == 4'd15) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_pend_on <= r_snap_on;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; the *_on flags gate whether they are shown.
    always_ff @(posedge clk) begin
        if (w_boundary) begin
            r_disp_bcd <= r_pend_bcd;
            r_snap_val <= w_sel_val;
        end else begin
            case (r_state)
                S_LOAD:  r_dd       <= {20'd0, r_snap_val};
                S_SHIFT: r_dd       <= f_dd_step(r_dd);
                S_DONE:  r_pend_bcd <= r_dd[35:16];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en  <= 4'b1111;
            seg <= 7'b0000000;
            dp  <= 1'b0;
        end else if (r_slot < SLOT_VIS) begin
            en  <= 4'b1111;
            seg <= 7'b0000000;
            dp  <= 1'b0;
        end else begin
            en  <= ~(4'b0001 << r_digit);
            seg <= w_glyph;
            dp  <= r_disp_on && (r_digit == r_page);
        end
    end

endmodule

// File: tb/tb_vout_7seg_pager.sv
// Bench for vout_7seg_pager: arithmetic display model compared every cycle,
// plus directed scenarios with literal glyph/page expectations.
module tb_vout_7seg_pager;

    localparam int SD = 32;
    localparam int BL = 4;
    localparam int DW = 2;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value0, value1, value2, value3;
    logic [3:0]  valid;
    logic        hold;
    logic [3:0]  en;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  page;

    int n_cmp = 0;
    int n_bad = 0;

    int       m_t = 0;
    int       m_page = 0;
    int       m_dwell = 0;
    bit       m_pend_on = 0;
    int       m_pend_val = 0;
    bit       m_disp_on = 0;
    int       m_disp_val = 0;
    int       m_slot, m_dig, m_sel;
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;

    always #5 clk = ~clk;

    vout_7seg_pager #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .DWELL_FRAMES(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .value0(value0), .value1(value1), .value2(value2), .value3(value3),
        .valid(valid), .hold(hold),
        .en(en), .seg(seg), .dp(dp), .page(page)
    );

    function automatic logic [6:0] glyph_of(int d);
        case (d)
            0: return 7'b0111111;  1: return 7'b0000110;
            2: return 7'b1011011;  3: return 7'b1001111;
            4: return 7'b1100110;  5: return 7'b1101101;
            6: return 7'b1111101;  7: return 7'b0000111;
            8: return 7'b1111111;  default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(bit on, int v, int dig);
        int p;
        p = (dig == 0) ? 1 : (dig == 1) ? 10 : (dig == 2) ? 100 : 1000;
        if (!on) return 7'b0000000;
        if (v > 9999) return 7'b1000000;
        if (dig > 0 && v < p) return 7'b0000000;
        return glyph_of((v / p) % 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Returns at the negedge after the edge whose pre-edge scan state is (frame f, digit d, slot s).
    task automatic at(input int f, input int d, input int s);
        int target;
        int guard;
        target = f * FR + d * SD + s + 1;
        guard = 0;
        while (m_t != target) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_timeout: reached t=%0d, wanted t=%0d", m_t, target);
                return;
            end
        end
    endtask

    // Reference model: one step per clock edge, outputs derived from the pre-edge state.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_t = 0; m_page = 0; m_dwell = 0;
                m_pend_on = 0; m_disp_on = 0;
                e_en = 4'b1111; e_seg = 7'b0; e_dp = 1'b0;
            end else begin
                m_slot = m_t % SD;
                m_dig  = (m_t / SD) % 4;
                if (m_slot < BL) begin
                    e_en = 4'b1111; e_seg = 7'b0; e_dp = 1'b0;
                end else begin
                    e_en = 4'b1111;
                    e_en[m_dig] = 1'b0;
                    e_seg = model_seg(m_disp_on, m_disp_val, m_dig);
                    e_dp = m_disp_on && (m_dig == m_page);
                end
                if (m_t == 0 || (m_slot == SD - 1 && m_dig == 3)) begin
                    m_disp_on  = m_pend_on;
                    m_disp_val = m_pend_val;
                    if (valid == 4'b0000) begin
                        m_dwell = 0;
                    end else if (!valid[m_page] || (m_t != 0 && !hold && m_dwell == DW - 1)) begin
                        m_dwell = 0;
                        for (int k = 1; k <= 4; k++) begin
                            if (valid[(m_page + k) % 4]) begin
                                m_page = (m_page + k) % 4;
                                break;
                            end
                        end
                    end else if (m_t != 0 && m_dwell < DW - 1) begin
                        m_dwell++;
                    end
                    m_sel = (m_page == 0) ? int'(value0) : (m_page == 1) ? int'(value1) :
                            (m_page == 2) ? int'(value2) : int'(value3);
                    m_pend_on  = (valid != 4'b0000);
                    m_pend_val = m_sel;
                end
                m_t++;
            end
            #1;
            chk("en", 32'(en), 32'(e_en));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("page", 32'(page), 32'(m_page));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; hold = 1'b0; valid = 4'b0001;
        value0 = 16'd1234; value1 = 16'd0; value2 = 16'd0; value3 = 16'd0;
        repeat (5) @(negedge clk);
        chk("rst_en", 32'(en), 32'hF);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        rst_n = 1'b1;

        at(0, 0, 10); chk("f0_blank_seg", 32'(seg), 32'h0); chk("f0_en", 32'(en), 32'b1110);
        at(1, 0, 2);  chk("blank_win_en", 32'(en), 32'hF);  chk("blank_win_seg", 32'(seg), 32'h0);
        at(1, 0, 10); chk("d0_1234", 32'(seg), 32'b1100110); chk("dp_d0", 32'(dp), 32'h1);
        at(1, 3, 10); chk("d3_1234", 32'(seg), 32'b0000110); chk("en_d3", 32'(en), 32'b0111);
        chk("dp_d3", 32'(dp), 32'h0);
        value0 = 16'd7;
        at(3, 0, 10); chk("d0_7", 32'(seg), 32'b0000111);
        at(3, 1, 10); chk("d1_7_lz", 32'(seg), 32'h0);
        value0 = 16'd0;
        at(5, 0, 10); chk("d0_zero", 32'(seg), 32'b0111111);
        at(5, 2, 10); chk("d2_zero_lz", 32'(seg), 32'h0);
        value0 = 16'd12345;
        at(7, 0, 10); chk("d0_ovf", 32'(seg), 32'b1000000);
        at(7, 3, 10); chk("d3_ovf", 32'(seg), 32'b1000000);

        @(negedge clk); rst_n = 1'b0;
        valid = 4'b1011; value0 = 16'd5; value1 = 16'd42; value3 = 16'd9876;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        at(0, 0, 20); chk("rot_f0", 32'(page), 32'd0);
        at(1, 0, 20); chk("rot_f1", 32'(page), 32'd0);
        at(2, 0, 10); chk("rot_f2", 32'(page), 32'd1);
        chk("f2_shows_p0", 32'(seg), 32'b1101101); chk("f2_dp_d0", 32'(dp), 32'h0);
        at(2, 1, 10); chk("f2_dp_newpage", 32'(dp), 32'h1);
        at(3, 0, 10); chk("rot_f3", 32'(page), 32'd1); chk("f3_d0_42", 32'(seg), 32'b1011011);
        at(3, 1, 10); chk("f3_d1_42", 32'(seg), 32'b1100110); chk("f3_dp", 32'(dp), 32'h1);
        at(4, 0, 20); chk("rot_f4", 32'(page), 32'd3);
        at(5, 0, 10); chk("rot_f5", 32'(page), 32'd3); chk("f5_d0_9876", 32'(seg), 32'b1111101);
        at(5, 3, 10); chk("f5_d3_9876", 32'(seg), 32'b1101111); chk("f5_dp", 32'(dp), 32'h1);
        at(6, 0, 20); chk("rot_f6", 32'(page), 32'd0);

        @(negedge clk); rst_n = 1'b0; valid = 4'b1011; hold = 1'b0;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        at(2, 1, 0);  chk("vd_f2", 32'(page), 32'd1); valid = 4'b1001;
        at(3, 0, 20); chk("vd_drop_to3", 32'(page), 32'd3); hold = 1'b1;
        at(6, 0, 20); chk("vd_hold_stay", 32'(page), 32'd3); valid = 4'b0001;
        at(7, 0, 20); chk("vd_hold_drop", 32'(page), 32'd0); valid = 4'b0000;
        at(8, 0, 10); chk("vd_f8_seg", 32'(seg), 32'b1101101); chk("vd_f8_dp", 32'(dp), 32'h1);
        at(9, 0, 10); chk("vd_none_seg", 32'(seg), 32'h0); chk("vd_none_dp", 32'(dp), 32'h0);
        chk("vd_none_page", 32'(page), 32'd0);

        @(negedge clk); rst_n = 1'b0; hold = 1'b0; valid = 4'b0001; value0 = 16'd1234;
        repeat (2) @(negedge clk); rst_n = 1'b1;
        at(1, 0, 10); chk("mc_pre_seg", 32'(seg), 32'b1100110);
        at(2, 0, 4);
        rst_n = 1'b0; value0 = 16'd8;
        @(negedge clk);
        chk("mc_rst_en", 32'(en), 32'hF); chk("mc_rst_seg", 32'(seg), 32'h0);
        chk("mc_rst_dp", 32'(dp), 32'h0); chk("mc_rst_page", 32'(page), 32'd0);
        rst_n = 1'b1;
        at(0, 0, 10); chk("mc_f0_blank", 32'(seg), 32'h0);
        at(1, 0, 10); chk("mc_f1_fresh", 32'(seg), 32'b1111111);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
